// File: rtl/sobel_stream_core.sv
// sobel_stream_core: streaming 3x3 Sobel edge detector.
//
// The core takes one unsigned pixel per cycle in raster order and keeps two
// line buffers of IMG_W pixels each. It builds a 3x3 window and produces one
// gradient magnitude and edge flag for each interior pixel. Input and output
// are valid/ready streams. One advance signal (adv) moves the whole pipeline,
// so backpressure on the output stalls the input directly.
//
// Optional feature macro: SOBEL_SQRT_MAG_EN
//   defined   : m_mag = floor(sqrt(Gx^2 + Gy^2))
//   undefined : m_mag = |Gx| + |Gy|
//
// Ports:
//   clk, reset        rising-edge clock, synchronous active-high reset
//   thr               edge threshold, used when S2 registers a result
//   s_valid/s_ready   input pixel handshake; s_data carries the pixel
//   m_valid/m_ready   result handshake
//   m_mag, m_edge     magnitude, and the flag (m_mag >= thr)
//   m_last            marks the result for center (IMG_H-2, IMG_W-2)
//   done              one-cycle pulse after the m_last beat is accepted
module sobel_stream_core #(
  parameter int PIX_W = 8,
  parameter int IMG_W = 640,
  parameter int IMG_H = 480,
  parameter int OUT_W = PIX_W + 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [OUT_W-1:0] thr,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [PIX_W-1:0] s_data,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [OUT_W-1:0] m_mag,
  output logic             m_edge,
  output logic             m_last,
  output logic             done
);

  localparam int SW     = PIX_W + 3;  // signed gradient width
  localparam int CW     = $clog2(IMG_W);
  localparam int RW     = $clog2(IMG_H);
  localparam int STAGES = 2;

  // [0] = window complete (S0), [1] = Gx/Gy held (S1), [2] = output (S2)
  logic [STAGES:0] vld_pipe, last_pipe;

  logic adv, acc;
  logic [CW-1:0] col;
  logic [RW-1:0] row;
  logic col_end, row_end;

  assign adv     = !m_valid || m_ready;
  assign s_ready = adv;
  assign acc     = s_valid && adv;
  assign col_end = (col == CW'(IMG_W - 1));
  assign row_end = (row == RW'(IMG_H - 1));
  assign m_valid = vld_pipe[STAGES];
  assign m_last  = last_pipe[STAGES];

  // Line buffers are indexed by column. lb1[col] holds pixel (r-1, col) and
  // lb2[col] holds pixel (r-2, col). Each write moves the row down by one line.
  logic [PIX_W-1:0] lb1 [IMG_W];
  logic [PIX_W-1:0] lb2 [IMG_W];
  logic [PIX_W-1:0] top_px, mid_px;

  assign top_px = lb2[col];
  assign mid_px = lb1[col];

  always_ff @(posedge clk) begin
    if (acc) begin
      lb1[col] <= s_data;
      lb2[col] <= mid_px;
    end
  end

  // Window layout is win[row][col]. Row 0 is the oldest line and col 2 is the
  // newest column. Window contents are don't-care until vld_pipe[0] is set.
  logic [PIX_W-1:0] win [3][3];

  always_ff @(posedge clk) begin
    if (acc) begin
      for (int r = 0; r < 3; r++) begin
        win[r][0] <= win[r][1];
        win[r][1] <= win[r][2];
      end
      win[0][2] <= top_px;
      win[1][2] <= mid_px;
      win[2][2] <= s_data;
    end
  end

  function automatic logic signed [SW-1:0] ext(input logic [PIX_W-1:0] p);
    return $signed({3'b000, p});
  endfunction

  // Gx is the right column minus the left column. Gy is the bottom row minus
  // the top row. Weights are 1,2,1. The width SW holds +/-4*(2^PIX_W-1).
  logic signed [SW-1:0] gx_c, gy_c, gx, gy;

  always_comb begin
    gx_c = (ext(win[0][2]) + (ext(win[1][2]) <<< 1) + ext(win[2][2]))
         - (ext(win[0][0]) + (ext(win[1][0]) <<< 1) + ext(win[2][0]));
    gy_c = (ext(win[2][0]) + (ext(win[2][1]) <<< 1) + ext(win[2][2]))
         - (ext(win[0][0]) + (ext(win[0][1]) <<< 1) + ext(win[0][2]));
  end

  always_ff @(posedge clk) begin
    if (adv && vld_pipe[0]) begin
      gx <= gx_c;
      gy <= gy_c;
    end
  end

  logic [SW-1:0]    ax, ay;
  logic [OUT_W-1:0] mag_c;

  assign ax = gx[SW-1] ? $unsigned(-gx) : $unsigned(gx);
  assign ay = gy[SW-1] ? $unsigned(-gy) : $unsigned(gy);

`ifdef SOBEL_SQRT_MAG_EN
  // Digit-by-digit integer square root. It runs a fixed SW iterations and
  // unrolls into combinational logic.
  function automatic logic [SW-1:0] isqrt(input logic [2*SW-1:0] x);
    logic [2*SW-1:0] op, res, one;
    op  = x;
    res = '0;
    one = (2*SW)'(1) << (2*SW - 2);
    for (int i = 0; i < SW; i++) begin
      if (op >= res + one) begin
        op  = op - (res + one);
        res = (res >> 1) + one;
      end else begin
        res = res >> 1;
      end
      one = one >> 2;
    end
    return res[SW-1:0];
  endfunction

  logic [2*SW-1:0] ax2, ay2, sum2;

  always_comb begin
    ax2   = (2*SW)'(ax);
    ay2   = (2*SW)'(ay);
    sum2  = ax2 * ax2 + ay2 * ay2;
    // The root is below 2^SW and OUT_W >= SW, so it never needs to clip.
    mag_c = OUT_W'(isqrt(sum2));
  end
`else
  logic [SW:0] l1;

  always_comb begin
    l1 = {1'b0, ax} + {1'b0, ay};
    // Saturate when OUT_W is too narrow for the L1 sum. With 3 guard bits
    // the sum fits, so this branch is a safety net.
    if (OUT_W > SW) mag_c = OUT_W'(l1);
    else            mag_c = l1[SW] ? '1 : OUT_W'(l1);
  end
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      col       <= '0;
      row       <= '0;
      vld_pipe  <= '0;
      last_pipe <= '0;
      m_mag     <= '0;
      m_edge    <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= m_valid && m_ready && m_last;
      if (acc) begin
        if (col_end) begin
          col <= '0;
          row <= row_end ? '0 : row + RW'(1);
        end else begin
          col <= col + CW'(1);
        end
      end
      if (adv) begin
        // A pixel at (r,c) with r,c >= 2 completes the window for center
        // (r-1, c-1). Any other cycle puts a bubble into S0.
        vld_pipe[0]            <= acc && (row >= RW'(2)) && (col >= CW'(2));
        last_pipe[0]           <= acc && row_end && col_end;
        vld_pipe[STAGES:1]     <= vld_pipe[STAGES-1:0];
        last_pipe[STAGES:1]    <= last_pipe[STAGES-1:0];
        if (vld_pipe[1]) begin
          m_mag  <= mag_c;
          m_edge <= (mag_c >= thr);
        end
      end
    end
  end

endmodule

// File: doc/sobel_stream_core.md
Name: sobel_stream_core

Overview:
Streaming, parametrised Sobel edge detector. It accepts one grayscale pixel per cycle in raster order over a valid/ready stream, builds 3x3 windows from two internal line buffers, and computes Gx/Gy and the gradient magnitude. It emits one magnitude/edge result per interior pixel, with backpressure. It replaces the controller-driven, fixed-width convolution top, so the pixel source and sink can be any streaming block.

Parameters:
PIX_W, 8, input pixel width (unsigned)
IMG_W, 640, pixels per line (>=3)
IMG_H, 480, lines per frame (>=3)
OUT_W, PIX_W+3, magnitude output width (must be >= PIX_W+3)

Ports:
clk  in  1  clock, rising edge
reset  in  1  synchronous, active-high reset
thr  in  OUT_W  edge threshold, sampled in magnitude stage
s_valid  in  1  input pixel valid
s_ready  out  1  core can accept pixel
s_data  in  PIX_W  input pixel, raster order, frame starts at (0,0)
m_valid  out  1  result valid
m_ready  in  1  sink accepts result
m_mag  out  OUT_W  gradient magnitude
m_edge  out  1  1 when m_mag >= thr
m_last  out  1  marks last interior result of frame
done  out  1  one-cycle pulse after m_last beat is accepted

Behaviour:
- Reset (synchronous, active-high): m_valid, m_mag, m_edge, m_last, done all = 0. Column and row counters = 0. Pipeline valid bits = 0. Line-buffer contents are not cleared (don't-care). s_ready = 1 in the first cycle after reset.
- Global advance: adv = !m_valid || m_ready. s_ready = adv. Input is accepted on s_valid && s_ready.
- Counters: col increments per accepted pixel. At col == IMG_W-1, col wraps to 0 and row increments. At row == IMG_H-1 with col == IMG_W-1, both wrap to 0 and a new frame begins.
- Line buffers: two IMG_W-deep RAMs/shift chains hold rows r-1 and r-2, written on acceptance. A 3x3 window register shifts on acceptance.
- Window valid: the accepted pixel (r,c) has r>=2 and c>=2. The result is for center (r-1,c-1). Border pixels produce no output. Each frame yields (IMG_W-2)*(IMG_H-2) results.
- Convolution conventions: Gx = right column minus left column. Gy = bottom row minus top row. Weights are 1,2,1. Signed width is PIX_W+3, and no overflow is possible.
- Pipeline:
  - S0: window update on acceptance.
  - S1: Gx/Gy registered.
  - S2: m_mag = |Gx|+|Gy| (saturated to OUT_W) and m_edge registered.
  - All stages move only when adv = 1.
- Latency: a window-completing pixel accepted at edge T gives m_valid = 1 after edge T+2, when m_ready stays high. Sustained throughput is 1 result per cycle.
- Stall: when m_valid && !m_ready, the m_mag/m_edge/m_last outputs hold stable, all stages freeze, and s_ready = 0.
- Bubbles: an invalid S1 entry propagates as m_valid = 0. It never produces a spurious output.
- m_last: set with the result for center (IMG_H-2, IMG_W-2).
- done: asserted for exactly one cycle, the cycle after the m_last beat handshakes.
- Frame boundaries: counter wrap and the next frame's pixel acceptance may occur in the same cycle as the previous frame's m_last. No stall is inserted between frames.
- Reset mid-frame: in-flight results are discarded, and the next accepted pixel is (0,0).
- thr changes: take effect for the result registered in the next S2 update.

Optional Feature:
- SOBEL_SQRT_MAG_EN defined: m_mag = floor(sqrt(Gx^2+Gy^2)), saturated to OUT_W. It is computed by a combinational integer square root in S2 over a 2*(PIX_W+3)-bit unsigned sum. Latency and handshake are unchanged.
- SOBEL_SQRT_MAG_EN undefined: m_mag = |Gx|+|Gy| (L1). No square root is synthesised.

Test Plan:
All tests use IMG_W=5, IMG_H=4, PIX_W=8, so each frame gives 6 results.
- Flat frame, all pixels 100, thr=1: 6 results, all m_mag=0, m_edge=0. m_last on the 6th result. done pulses the cycle after that beat.
- Vertical step, cols 0-1 = 0 and cols 2-4 = 255, thr=500: per row, m_mag = 1020, 1020, 0 and m_edge = 1, 1, 0. First m_valid comes 2 cycles after accepting pixel (2,2).
- Single pixel 255 at (1,1), rest 0, thr=0:
  - Center (2,2) gives m_mag=510 by default.
  - With SOBEL_SQRT_MAG_EN, it gives m_mag=360.
  - Center (1,1) gives m_mag=0.
- Backpressure: hold m_ready=0 for 5 cycles mid-frame while s_valid=1. Outputs are held, s_ready=0, and no results are lost or duplicated. The sequence matches the unstalled golden model.
- Random s_valid gaps plus random m_ready over 3 back-to-back frames: exactly 18 results, 3 m_last, 3 done pulses, with values matching a software model.
- Assert reset after 9 pixels of a frame, then send a full frame: no output from the aborted frame. Exactly 6 correct results and one done pulse.
